// File: rtl/comp_serial_seq.sv
// comp_serial_seq
//   Bit-serial magnitude-compare sequencer. An accepted start captures two
//   WIDTH-bit operands. The operands are walked from MSB to LSB, one bit per
//   clock, through a 1-bit equal/greater/less slice. A one-hot aeb/agb/alb
//   result is reported together with a single-cycle done pulse.
//
// Ports
//   clk    in   1      clock, rising edge
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      compare request, only looked at in IDLE
//   abort  in   1      cancels an in-flight compare (SCAN only)
//   a, b   in   WIDTH  operands, captured on an accepted start
//   busy   out  1      state != IDLE
//   done   out  1      one-cycle pulse, result valid
//   aeb    out  1      A == B, held until the next accepted start
//   agb    out  1      A >  B, held
//   alb    out  1      A <  B, held
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; result flags hold the previous outcome
// SCAN  | one operand bit compared per clock, idx counts down to 0
// DONE  | done pulse cycle; returns to IDLE on the next edge

module comp_serial_seq #(
  parameter int WIDTH      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             aeb,
  output logic             agb,
  output logic             alb
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    DEC_NONE = 2'd0,
    DEC_GT   = 2'd1,
    DEC_LT   = 2'd2
  } dec_t;

  state_t           state;
  dec_t             dec;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IDX_W-1:0] idx;

  logic bit_a;
  logic bit_diff;
  logic last_bit;
  dec_t dec_nxt;

  // The 1-bit compare slice. The first differing bit (from the MSB) fixes the
  // decision; any later difference is less significant and must not change it.
  always_comb begin
    bit_a    = a_q[idx];
    bit_diff = a_q[idx] ^ b_q[idx];
    dec_nxt  = dec;
    if ((dec == DEC_NONE) && bit_diff) begin
      dec_nxt = bit_a ? DEC_GT : DEC_LT;
    end
    last_bit = (idx == '0) || ((EARLY_EXIT != 0) && bit_diff);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      dec   <= DEC_NONE;
      a_q   <= '0;
      b_q   <= '0;
      idx   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      aeb   <= 1'b0;
      agb   <= 1'b0;
      alb   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // start takes priority over a simultaneous abort here
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            idx   <= IDX_MAX;
            dec   <= DEC_NONE;
            aeb   <= 1'b0;
            agb   <= 1'b0;
            alb   <= 1'b0;
            busy  <= 1'b1;
            state <= S_SCAN;
          end
        end
        S_SCAN: begin
          // abort beats a terminating bit in the same cycle: no done, flags stay 000
          if (abort) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            dec <= dec_nxt;
            if (last_bit) begin
              done  <= 1'b1;
              aeb   <= (dec_nxt == DEC_NONE);
              agb   <= (dec_nxt == DEC_GT);
              alb   <= (dec_nxt == DEC_LT);
              state <= S_DONE;
            end else begin
              idx <= idx - 1'b1;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comp_serial_seq.sv
// tb_comp_serial_seq
//   Drives two instances side by side from the same stimulus: one with
//   early exit enabled (ee) and one that always scans every bit (fs).
//   Expected results come from plain magnitude comparison and the position of
//   the most significant differing bit.

module tb_comp_serial_seq;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;

  logic busy0, done0, aeb0, agb0, alb0;
  logic busy1, done1, aeb1, agb1, alb1;

  int n_tests = 0;
  int n_fail  = 0;

  comp_serial_seq #(.WIDTH(W), .EARLY_EXIT(1)) u_ee (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .a(a), .b(b),
    .busy(busy0), .done(done0), .aeb(aeb0), .agb(agb0), .alb(alb0)
  );

  comp_serial_seq #(.WIDTH(W), .EARLY_EXIT(0)) u_fs (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .a(a), .b(b),
    .busy(busy1), .done(done1), .aeb(aeb1), .agb(agb1), .alb(alb1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] flags_of(input int i);
    return (i == 0) ? {aeb0, agb0, alb0} : {aeb1, agb1, alb1};
  endfunction

  function automatic logic busy_of(input int i);
    return (i == 0) ? busy0 : busy1;
  endfunction

  function automatic logic done_of(input int i);
    return (i == 0) ? done0 : done1;
  endfunction

  // Cycles from the accepting edge until done is visible.
  function automatic int exp_lat(input logic [W-1:0] x, input logic [W-1:0] y, input bit ee);
    logic [W-1:0] d;
    d = x ^ y;
    if (!ee || d == '0) return W;
    for (int i = W - 1; i >= 0; i--) begin
      if (d[i]) return W - i;
    end
    return W;
  endfunction

  function automatic logic [2:0] exp_flags(input logic [W-1:0] x, input logic [W-1:0] y);
    if (x == y) return 3'b100;
    if (x > y)  return 3'b010;
    return 3'b001;
  endfunction

  // One compare on both instances. abort_cyc is the SCAN cycle (0 = first
  // cycle after the accepting edge) in which abort is held high; -1 = none.
  task automatic do_compare(input logic [W-1:0] av, input logic [W-1:0] bv,
                            input bit scramble, input int abort_cyc,
                            input bit abort_with_start, input string tag);
    int first [2];
    int nbusy [2];
    int ndone [2];
    int eflags[2];
    int lat;
    bit aborted;
    for (int i = 0; i < 2; i++) begin
      first[i] = -1; nbusy[i] = 0; ndone[i] = 0; eflags[i] = 0;
    end
    @(negedge clk);
    a = av; b = bv; start = 1'b1; abort = abort_with_start;
    @(posedge clk);
    #1;
    for (int k = 0; k <= W + 3; k++) begin
      if (k > 0) begin
        @(negedge clk);
        start = (scramble && busy0 && busy1) ? 1'($urandom % 2) : 1'b0;
        if (scramble) begin
          a = W'($urandom);
          b = W'($urandom);
        end
        abort = (k - 1 == abort_cyc);
        @(posedge clk);
        #1;
      end
      for (int i = 0; i < 2; i++) begin
        if (busy_of(i)) nbusy[i]++;
        if (done_of(i)) begin
          ndone[i]++;
          if (first[i] < 0) first[i] = k;
        end else if (first[i] < 0 && flags_of(i) != 3'b000) begin
          eflags[i]++;
        end
      end
    end
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 2; i++) begin
      string nm;
      nm      = $sformatf("%s/%s", tag, (i == 0) ? "ee" : "fs");
      lat     = exp_lat(av, bv, i == 0);
      aborted = (abort_cyc >= 0) && (abort_cyc < lat);
      check({nm, " latency"},     32'(first[i]), aborted ? 32'hFFFF_FFFF : 32'(lat));
      check({nm, " done_count"},  32'(ndone[i]), aborted ? 32'd0 : 32'd1);
      check({nm, " busy_cycles"}, 32'(nbusy[i]), aborted ? 32'(abort_cyc + 1) : 32'(lat + 1));
      check({nm, " flags_early"}, 32'(eflags[i]), 32'd0);
      check({nm, " flags"},       32'(flags_of(i)), aborted ? 32'd0 : 32'(exp_flags(av, bv)));
    end
  endtask

  initial begin
    // 1: reset held with inputs toggling
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      start = 1'($urandom % 2); abort = 1'($urandom % 2);
      a = W'($urandom); b = W'($urandom);
      @(posedge clk);
      #1;
      check("reset_outputs", {busy0, done0, aeb0, agb0, alb0, busy1, done1, aeb1, agb1, alb1}, 32'd0);
    end
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // 2: equal operands, then result held while idle
    do_compare(8'hA5, 8'hA5, 1'b0, -1, 1'b0, "eq_a5");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      a = W'($urandom); b = W'($urandom);
      @(posedge clk);
      #1;
      check("eq_held", {aeb0, agb0, alb0, aeb1, agb1, alb1}, 32'b100_100);
    end

    // 3/4: MSB decides; later opposite differences ignored
    do_compare(8'h80, 8'h7F, 1'b0, -1, 1'b0, "msb_gt");
    do_compare(8'h12, 8'h13, 1'b0, -1, 1'b0, "lsb_lt");

    // 5: restart attempts and changing operands while busy, then abort
    do_compare(8'h01, 8'h00, 1'b1, -1, 1'b0, "scramble");
    do_compare(8'h5A, 8'h5A, 1'b0,  2, 1'b0, "abort_c2");
    do_compare(8'h33, 8'h3C, 1'b0, -1, 1'b1, "abort_with_start");

    // 6: async reset in the middle of a SCAN cycle
    @(negedge clk);
    a = 8'h3C; b = 8'h3C; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_outputs", {busy0, done0, aeb0, agb0, alb0, busy1, done1, aeb1, agb1, alb1}, 32'd0);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      check("rst_no_done", {done0, done1}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_compare(8'h00, 8'hFF, 1'b0, -1, 1'b0, "post_rst_lt");

    // randomized compares with occasional abort
    for (int t = 0; t < 40; t++) begin
      logic [W-1:0] ra, rb;
      int ac;
      ra = W'($urandom);
      case ($urandom % 4)
        0:       rb = ra;
        1:       rb = ra ^ W'(1 << $urandom_range(0, W - 1));
        default: rb = W'($urandom);
      endcase
      ac = ($urandom % 4 == 0) ? int'($urandom_range(0, 9)) : -1;
      do_compare(ra, rb, 1'($urandom % 2), ac, 1'($urandom % 2), $sformatf("rnd%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
